// File: rtl/div_seq_sm.sv
// Sequential restoring divider: one quotient bit per clock, start/ready/done_tick handshake.
// Define DIV_SIGNED_EN to honour sgn (signed magnitude prep, sign fix-up and ovf flag).
module div_seq_sm #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         sgn,
    input  logic [W-1:0] dvnd,
    input  logic [W-1:0] dvsr,
    output logic         ready,
    output logic         done_tick,
    output logic [W-1:0] quo,
    output logic [W-1:0] rmd,
    output logic         dbz,
    output logic         ovf
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

`ifdef DIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, PREP, OP, FIX, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  q_r;
    logic [W-1:0]  d_r;
    logic [W:0]    r_r;
    logic [CW-1:0] cnt;
    logic          sgn_r;
    logic          neg_n;
    logic          neg_d;
    logic          sgn_eff;

    logic [W:0]    r_sh;
    logic [W:0]    r_sub;
    logic          q_bit;

    assign sgn_eff = sgn & SIGNED_EN;

    always_comb begin
        r_sh  = (r_r << 1) | (W+1)'(q_r[W-1]);
        r_sub = r_sh - {1'b0, d_r};
        q_bit = (r_sh >= {1'b0, d_r});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done_tick = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = (dvsr == '0) ? DONE : PREP;
            end
            PREP: state_nxt = OP;
            OP:   if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                done_tick = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r   <= '0;
            d_r   <= '0;
            r_r   <= '0;
            cnt   <= '0;
            sgn_r <= 1'b0;
            neg_n <= 1'b0;
            neg_d <= 1'b0;
            quo   <= '0;
            rmd   <= '0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    q_r   <= dvnd;
                    d_r   <= dvsr;
                    r_r   <= '0;
                    sgn_r <= sgn_eff;
                    neg_n <= sgn_eff & dvnd[W-1];
                    neg_d <= sgn_eff & dvsr[W-1];
                    dbz   <= (dvsr == '0);
                    ovf   <= 1'b0;
                    if (dvsr == '0) begin
                        quo <= '1;
                        rmd <= dvnd;
                    end
                end
                PREP: begin
                    // |MIN| = 2^(W-1) still fits as W-bit unsigned, so MIN/-1 needs no special path
                    if (neg_n) q_r <= -q_r;
                    if (neg_d) d_r <= -d_r;
                    ovf <= sgn_r && (q_r == MIN_VAL) && (d_r == '1);
                    cnt <= CW'(W);
                end
                OP: begin
                    r_r <= q_bit ? r_sub : r_sh;
                    q_r <= {q_r[W-2:0], q_bit};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    quo <= (neg_n ^ neg_d) ? -q_r : q_r;
                    rmd <= neg_n ? -r_r[W-1:0] : r_r[W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_sm.sv
// Directed and model-checked bench for div_seq_sm at W=8; expectations follow DIV_SIGNED_EN.
module tb_div_seq_sm;

    localparam int unsigned W = 8;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] dvnd = '0;
    logic [W-1:0] dvsr = '0;
    logic         ready, done_tick, dbz, ovf;
    logic [W-1:0] quo, rmd;

    int unsigned passes = 0;
    int unsigned fails  = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    div_seq_sm #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sgn       (sgn),
        .dvnd      (dvnd),
        .dvsr      (dvsr),
        .ready     (ready),
        .done_tick (done_tick),
        .quo       (quo),
        .rmd       (rmd),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents operands with start for one edge; returns #1 into cycle 1.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        dvnd  = a;
        dvsr  = b;
        sgn   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done_tick !== 1'b1 && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic ez, input logic eo, input int ecyc);
        int cyc;
        launch(a, b, s);
        wait_done(cyc);
        check({tag, ".done_cyc"}, cyc, ecyc);
        check({tag, ".quo"}, quo, eq);
        check({tag, ".rmd"}, rmd, er);
        check({tag, ".dbz"}, dbz, ez);
        check({tag, ".ovf"}, ovf, eo);
        check({tag, ".busy_in_done"}, ready, 1'b0);
        @(posedge clk);
        #1;
        check({tag, ".ready_after"}, ready, 1'b1);
        check({tag, ".quo_hold"}, quo, eq);
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output logic o);
        int ai, bi;
        z = 1'b0;
        o = 1'b0;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (s && SIGNED_BUILD) begin
            ai = $signed(a);
            bi = $signed(b);
            q  = W'(ai / bi);
            r  = W'(ai % bi);
            o  = (a == 8'h80) && (b == 8'hFF);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'hFF;
            3: return 8'h80;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int cyc;
        bit seen;
        logic [W-1:0] a, b, eq, er;
        logic s, ez, eo;

        #12;
        check("rst.ready", ready, 1'b1);
        check("rst.done", done_tick, 1'b0);
        check("rst.quo", quo, 8'h00);
        check("rst.rmd", rmd, 8'h00);
        check("rst.dbz", dbz, 1'b0);
        check("rst.ovf", ovf, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        directed("u200_7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 1'b0, 11);
        if (SIGNED_BUILD) begin
            directed("s_m7_2", 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0, 11);
            directed("s_min_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 11);
            directed("s_7_m2", 8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 1'b0, 11);
        end else begin
            directed("s_m7_2", 8'hF9, 8'h02, 1'b1, 8'h7C, 8'h01, 1'b0, 1'b0, 11);
            directed("s_min_m1", 8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b0, 1'b0, 11);
            directed("s_7_m2", 8'h07, 8'hFE, 1'b1, 8'h00, 8'h07, 1'b0, 1'b0, 11);
        end
        directed("u_f9_2", 8'hF9, 8'h02, 1'b0, 8'd124, 8'd1, 1'b0, 1'b0, 11);
        directed("dbz", 8'h5A, 8'h00, 1'b0, 8'hFF, 8'h5A, 1'b1, 1'b0, 1);
        directed("u255_1", 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 11);

        // start raised in the DONE cycle must be ignored
        launch(8'd100, 8'd9, 1'b0);
        wait_done(cyc);
        check("done_start.cyc", cyc, 11);
        start = 1'b1;
        dvnd  = 8'd1;
        dvsr  = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_start.ready", ready, 1'b1);
        check("done_start.quo", quo, 8'd11);
        @(posedge clk);
        #1;
        check("done_start.idle", ready, 1'b1);
        check("done_start.rmd", rmd, 8'd1);

        // abort mid-operation with reset
        launch(8'd200, 8'd7, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        check("abort.ready", ready, 1'b1);
        check("abort.done", done_tick, 1'b0);
        check("abort.quo", quo, 8'h00);
        check("abort.rmd", rmd, 8'h00);
        check("abort.dbz", dbz, 1'b0);
        check("abort.ovf", ovf, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done_tick === 1'b1) seen = 1'b1;
        end
        check("abort.no_done", seen, 1'b0);
        directed("after_abort", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 1'b0, 11);

        // start held high: a new operation is taken in every ready cycle
        @(negedge clk);
        for (int i = 0; i < 150; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            model(a, b, s, eq, er, ez, eo);
            check("rnd.ready", ready, 1'b1);
            dvnd  = a;
            dvsr  = b;
            sgn   = s;
            start = 1'b1;
            @(posedge clk);
            #1;
            dvnd = W'($urandom);
            dvsr = W'($urandom);
            sgn  = 1'($urandom_range(0, 1));
            wait_done(cyc);
            check("rnd.cyc", cyc, (b == 0) ? 1 : 11);
            check("rnd.quo", quo, eq);
            check("rnd.rmd", rmd, er);
            check("rnd.dbz", dbz, ez);
            check("rnd.ovf", ovf, eo);
            @(negedge clk);
            @(negedge clk);
            check("rnd.quo_hold", quo, eq);
            check("rnd.rmd_hold", rmd, er);
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
